hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- EX-stage multi-cycle multiply/divide unit beside the ALU; owns the HI/LO registers.
- The EX stage starts it for MULT/MULTU/DIV/DIVU using the ALU-control sign flag, and serves MFHI/MFLO reads and MTHI/MTLO writes.
- Hazard logic stalls the pipeline on o_busy.
- Iterative radix-2 datapath: 33 cycles of deterministic latency for every operation.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals DATA_W.

Ports:
- i_clk  in  1  clock; every register updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_op  in  2  00 = MUL, 01 = DIV, 1x = reserved (start is ignored).
- i_sign  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); from ALU control.
- i_a  in  32  rs operand (multiplicand / dividend).
- i_b  in  32  rt operand (multiplier / divisor).
- i_mthi  in  1  write i_a into HI.
- i_mtlo  in  1  write i_a into LO.
- o_busy  out  1  operation in flight.
- o_done  out  1  one-cycle pulse: HI/LO updated.
- o_hi  out  32  HI register.
- o_lo  out  32  LO register.

Behaviour:
- Reset: state = IDLE; HI = LO = 0; o_busy = 0; o_done = 0; counter and working registers = 0. A reset in any state aborts the operation and HI/LO do not receive a result.
- FSM states:
  - IDLE: accepts a start.
  - CALC: 32 iterations.
  - FIX: sign correction, HI/LO write.
- IDLE -> CALC at edge E0 when i_start = 1 and i_op is 00 or 01. At E0:
  - latch op and sign flag;
  - latch |a| and |b| when signed (two's-complement magnitude), raw values otherwise;
  - latch neg_q = a[31]^b[31] and neg_r = a[31] (both forced to 0 when unsigned);
  - latch div0 = (op == DIV && b == 0);
  - count = 0.
- CALC, one iteration per edge, count++. CALC -> FIX at the edge where count == 31, i.e. edges E1..E32.
  - MUL: shift-add on a 64-bit product {P_hi, P_lo}. If the multiplier LSB is 1, add the multiplicand to P_hi with a 33-bit carry, then shift right 1.
  - DIV: restoring division. Shift the {rem, quo} pair left, trial-subtract the divisor (33-bit), and set the quotient bit on non-negative.
- FIX -> IDLE at E33, which writes HI/LO and drives o_done = 1 for the following cycle only.
  - MUL: {HI, LO} = neg_q ? -product (64-bit) : product.
  - DIV: LO = neg_q ? -quo : quo; HI = neg_r ? -rem : rem.
  - div0 overrides both: LO = 0xFFFFFFFF, HI = i_a as latched (raw), no sign fix. Latency is still 33.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural wrap, no trap).
- Timing summary:
  - o_busy = (state != IDLE), registered-state decode. It is 1 in the cycles after E0 through the cycle after E32, and 0 in the o_done cycle.
  - Results are visible on o_hi/o_lo from the cycle after E33.
- Reads: o_hi/o_lo continuously reflect the registers. During CALC/FIX they hold the previous values; the pipeline stalls on busy before MFHI/MFLO.
- MTHI/MTLO:
  - Effective only in IDLE; ignored while busy.
  - Asserted together with i_start in IDLE: the move commits at E0 and the operation still starts. Its result later overwrites HI/LO.
  - i_mthi and i_mtlo together write i_a to both registers.
- i_start while busy: ignored (no queueing). Inputs other than i_rst are don't-care outside IDLE.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MUL = 2'b00, MD_DIV = 2'b01;
  - FSM state encodings IDLE/CALC/FIX;
  - MIPS funct constants MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13, MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B, used by ALU control and hazard logic.
- One sub-module, md_negate: parameterised conditional two's-complement negate (width, enable). It is instantiated for the operand abs values and the FIX-stage 64-bit/32-bit sign fixes.

Test Plan:
- Unsigned MUL, a = 0xFFFFFFFF, b = 0xFFFFFFFF, sign = 0 -> after E33 HI = 0xFFFFFFFE, LO = 0x00000001; o_done high exactly 1 cycle; o_busy high 33 cycles.
- Signed MUL, a = -7 (0xFFFFFFF9), b = 6 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFD6 (-42); same operands unsigned -> HI = 0x00000005, LO = 0xFFFFFFD6.
- Signed DIV, a = -7, b = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); DIVU 7/2 -> LO = 3, HI = 1; signed 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- DIV by zero, a = 0x12345678, b = 0 -> LO = 0xFFFFFFFF, HI = 0x12345678 at E33; a second i_start at E5 is ignored and only one o_done occurs.
- MTHI a = 0xAAAA0000 in IDLE -> o_hi = 0xAAAA0000 next cycle; MTLO during busy -> LO unchanged until the result write.
- Reset asserted at E10 of a MUL -> next cycle IDLE, busy = 0, HI = LO = 0, no o_done; a new start immediately after reset completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes, FSM states,
// MIPS funct values and a funct decoder used by ALU control and hazard logic.
package muldiv_pkg;

  localparam logic [1:0] MD_MUL = 2'b00;
  localparam logic [1:0] MD_DIV = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  typedef struct packed {
    logic       start;
    logic [1:0] op;
    logic       sign;
    logic       mthi;
    logic       mtlo;
    logic       rd_hi;
    logic       rd_lo;
  } md_ctrl_t;

  // Maps an R-type funct field onto the unit's control inputs; rd_* flag the
  // MFHI/MFLO reads that must stall while the unit is busy.
  function automatic md_ctrl_t md_decode_funct(input logic [5:0] funct);
    md_ctrl_t c;
    c = '0;
    case (funct)
      MFHI:  c.rd_hi = 1'b1;
      MFLO:  c.rd_lo = 1'b1;
      MTHI:  c.mthi  = 1'b1;
      MTLO:  c.mtlo  = 1'b1;
      MULT:  begin c.start = 1'b1; c.op = MD_MUL; c.sign = 1'b1; end
      MULTU: begin c.start = 1'b1; c.op = MD_MUL; c.sign = 1'b0; end
      DIV:   begin c.start = 1'b1; c.op = MD_DIV; c.sign = 1'b1; end
      DIVU:  begin c.start = 1'b1; c.op = MD_DIV; c.sign = 1'b0; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the HI/LO multiply/divide unit (slave).
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              i_start;
  logic [1:0]        i_op;
  logic              i_sign;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              i_mthi;
  logic              i_mtlo;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;

  modport master (
    output i_start, i_op, i_sign, i_a, i_b, i_mthi, i_mtlo,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_sign, i_a, i_b, i_mthi, i_mtlo,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement negate: dout = en ? -din : din.
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? ((~din) + WIDTH'(1)) : din;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; fixed 33-cycle latency
// (32 magnitude iterations plus one sign-fix/write cycle).
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hilo_muldiv_unit_if.slave  md
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              is_div_q, is_div_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              div0_q, div0_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] raw_a_q, raw_a_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic                div_fits;
  logic [DATA_W-1:0]   div_sub;
  logic                op_ok;

  md_negate #(.WIDTH(DATA_W)) u_abs_a (
    .en   (md.i_sign & md.i_a[DATA_W-1]),
    .din  (md.i_a),
    .dout (a_abs)
  );

  md_negate #(.WIDTH(DATA_W)) u_abs_b (
    .en   (md.i_sign & md.i_b[DATA_W-1]),
    .din  (md.i_b),
    .dout (b_abs)
  );

  md_negate #(.WIDTH(2*DATA_W)) u_fix_prod (
    .en   (quo_neg_q),
    .din  ({acc_hi_q, acc_lo_q}),
    .dout (prod_fix)
  );

  md_negate #(.WIDTH(DATA_W)) u_fix_quo (
    .en   (quo_neg_q),
    .din  (acc_lo_q),
    .dout (quo_fix)
  );

  md_negate #(.WIDTH(DATA_W)) u_fix_rem (
    .en   (rem_neg_q),
    .din  (acc_hi_q),
    .dout (rem_fix)
  );

  // acc_hi/acc_lo hold the product halves for MUL and remainder/quotient for DIV;
  // opnd holds the multiplicand or the divisor.
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q & {DATA_W{acc_lo_q[0]}}};
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_fits  = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[DATA_W-1:0] - opnd_q;
  assign op_ok     = ~md.i_op[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (md.i_mthi) hi_d = md.i_a;
        if (md.i_mtlo) lo_d = md.i_a;
        if (md.i_start && op_ok) begin
          state_d   = CALC;
          is_div_d  = (md.i_op == MD_DIV);
          quo_neg_d = md.i_sign & (md.i_a[DATA_W-1] ^ md.i_b[DATA_W-1]);
          rem_neg_d = md.i_sign & md.i_a[DATA_W-1];
          div0_d    = (md.i_op == MD_DIV) && (md.i_b == '0);
          count_d   = '0;
          raw_a_d   = md.i_a;
          acc_hi_d  = '0;
          opnd_d    = (md.i_op == MD_DIV) ? b_abs : a_abs;
          acc_lo_d  = (md.i_op == MD_DIV) ? a_abs : b_abs;
        end
      end

      CALC: begin
        count_d = count_q + CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = div_fits ? div_sub : div_shift[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], div_fits};
        end else begin
          acc_hi_d = mul_sum[DATA_W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end
        if (count_q == LAST_ITER) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          // Divide by zero: all-ones quotient, dividend passed through raw.
          lo_d = '1;
          hi_d = raw_a_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q   <= '0;
      is_div_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md.o_busy = (state_q != IDLE);
  assign md.o_done = done_q;
  assign md.o_hi   = hi_q;
  assign md.o_lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO queued at start, checked on o_done.
module tb_hilo_muldiv_unit;

  logic clk;
  logic rst;

  hilo_muldiv_unit_if #(.DATA_W(32)) md_if ();

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .md    (md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic sign,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    if (op == 2'b00) begin
      if (sign) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (sign) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      qa = a;
      qb = b;
      return {32'(qa % qb), 32'(qa / qb)};
    end
    return {a % b, a / b};
  endfunction

  // Result checker: every o_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (md_if.o_done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq({e.tag, "_hi"}, {32'h0, md_if.o_hi}, {32'h0, e.hi});
        check_eq({e.tag, "_lo"}, {32'h0, md_if.o_lo}, {32'h0, e.lo});
      end
    end
  end

  // mode: 0 plain, 1 extra start at E5, 2 MTLO while busy, 3 MTHI together with start
  task automatic run_op(input string tag, input logic [1:0] op, input logic sign,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int mode);
    exp_t e;
    int   busy_cycles;
    bit   seen_done;
    e.tag = tag;
    e.hi  = ehi;
    e.lo  = elo;
    @(negedge clk);
    md_if.i_start = 1'b1;
    md_if.i_op    = op;
    md_if.i_sign  = sign;
    md_if.i_a     = a;
    md_if.i_b     = b;
    md_if.i_mthi  = (mode == 3);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    md_if.i_start = 1'b0;
    md_if.i_mthi  = 1'b0;
    busy_cycles = 0;
    seen_done   = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (md_if.o_done) begin
        seen_done = 1'b1;
        break;
      end
      if (md_if.o_busy) busy_cycles++;
      if (mode == 3 && k == 1) check_eq({tag, "_mthi_start"}, {32'h0, md_if.o_hi}, {32'h0, a});
      if (mode == 1 && k == 5) begin
        md_if.i_start = 1'b1;
        md_if.i_op    = 2'b01;
        md_if.i_b     = 32'h3;
      end
      if (mode == 1 && k == 6) md_if.i_start = 1'b0;
      if (mode == 2 && k == 3) begin
        md_if.i_mtlo = 1'b1;
        md_if.i_a    = 32'hDEADBEEF;
      end
      if (mode == 2 && k == 4) begin
        check_eq({tag, "_mtlo_busy"}, {32'h0, md_if.o_lo}, {32'h0, last_lo});
        md_if.i_mtlo = 1'b0;
      end
    end
    if (!seen_done) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
    check_eq({tag, "_done_busy_low"}, {63'h0, md_if.o_busy}, 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {63'h0, md_if.o_done}, 64'd0);
    $display("txn %s op=%0d sign=%0d a=%h b=%h hi=%h lo=%h busy_cycles=%0d",
             tag, op, sign, a, b, md_if.o_hi, md_if.o_lo, busy_cycles);
    last_hi = ehi;
    last_lo = elo;
  endtask

  task automatic mt_write(input string tag, input logic hi_en, input logic lo_en, input logic [31:0] val);
    @(negedge clk);
    md_if.i_mthi = hi_en;
    md_if.i_mtlo = lo_en;
    md_if.i_a    = val;
    @(posedge clk);
    #1;
    md_if.i_mthi = 1'b0;
    md_if.i_mtlo = 1'b0;
    if (hi_en) last_hi = val;
    if (lo_en) last_lo = val;
    @(negedge clk);
    check_eq({tag, "_hi"}, {32'h0, md_if.o_hi}, {32'h0, last_hi});
    check_eq({tag, "_lo"}, {32'h0, md_if.o_lo}, {32'h0, last_lo});
    $display("txn %s mthi=%0d mtlo=%0d a=%h hi=%h lo=%h", tag, hi_en, lo_en, val, md_if.o_hi, md_if.o_lo);
  endtask

  task automatic reserved_op(input logic [1:0] op);
    @(negedge clk);
    md_if.i_start = 1'b1;
    md_if.i_op    = op;
    md_if.i_a     = 32'h5;
    md_if.i_b     = 32'h7;
    @(posedge clk);
    #1;
    md_if.i_start = 1'b0;
    @(negedge clk);
    check_eq("rsvd_idle", {63'h0, md_if.o_busy}, 64'd0);
    $display("txn reserved op=%0d busy=%0d", op, md_if.o_busy);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic        r_sign;
    logic [31:0] r_a, r_b;
    logic [63:0] r_exp;

    rst           = 1'b1;
    md_if.i_start = 1'b0;
    md_if.i_op    = 2'b00;
    md_if.i_sign  = 1'b0;
    md_if.i_a     = '0;
    md_if.i_b     = '0;
    md_if.i_mthi  = 1'b0;
    md_if.i_mtlo  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", {63'h0, md_if.o_busy}, 64'd0);
    check_eq("reset_done", {63'h0, md_if.o_done}, 64'd0);
    check_eq("reset_hi", {32'h0, md_if.o_hi}, 64'd0);
    check_eq("reset_lo", {32'h0, md_if.o_lo}, 64'd0);
    rst = 1'b0;

    mt_write("mthi", 1'b1, 1'b0, 32'hAAAA0000);
    mt_write("mtlo", 1'b0, 1'b1, 32'h13579BDF);
    mt_write("mthilo", 1'b1, 1'b1, 32'h2468ACE0);

    run_op("mulu_max", 2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_m7x6", 2'b00, 1'b1, 32'hFFFFFFF9, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFD6, 0);
    run_op("multu_m7x6", 2'b00, 1'b0, 32'hFFFFFFF9, 32'h6, 32'h00000005, 32'hFFFFFFD6, 0);
    run_op("div_m7d2", 2'b01, 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu_7d2", 2'b01, 1'b0, 32'h7, 32'h2, 32'h1, 32'h3, 0);
    run_op("div_minneg", 2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    run_op("div0", 2'b01, 1'b1, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1);
    run_op("mtlo_busy", 2'b00, 1'b1, 32'h3, 32'h4, 32'h0, 32'hC, 2);
    run_op("mthi_start", 2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 3);

    // Reset in the middle of a MUL: no result, no o_done.
    @(negedge clk);
    md_if.i_start = 1'b1;
    md_if.i_op    = 2'b00;
    md_if.i_sign  = 1'b0;
    md_if.i_a     = 32'h5;
    md_if.i_b     = 32'h5;
    @(posedge clk);
    #1;
    md_if.i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_busy", {63'h0, md_if.o_busy}, 64'd0);
    check_eq("midrst_done", {63'h0, md_if.o_done}, 64'd0);
    check_eq("midrst_hi", {32'h0, md_if.o_hi}, 64'd0);
    check_eq("midrst_lo", {32'h0, md_if.o_lo}, 64'd0);
    $display("txn midreset busy=%0d hi=%h lo=%h", md_if.o_busy, md_if.o_hi, md_if.o_lo);
    rst     = 1'b0;
    last_hi = '0;
    last_lo = '0;
    run_op("post_reset", 2'b00, 1'b0, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 0);

    reserved_op(2'b10);
    reserved_op(2'b11);

    for (int i = 0; i < 8; i++) begin
      r_op   = {1'b0, i[0]};
      r_sign = i[1];
      r_a    = $urandom;
      r_b    = (i == 5) ? 32'h0 : ((i[2]) ? ($urandom & 32'hFFFF) : $urandom);
      r_exp  = model(r_op, r_sign, r_a, r_b);
      run_op($sformatf("rand%0d", i), r_op, r_sign, r_a, r_b, r_exp[63:32], r_exp[31:0], 0);
    end

    repeat (5) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
